// File: rtl/debug_run_controller.sv
// rtl/debug_run_controller.sv - host command decoder, program loader, core run gating and UART state dump
module debug_run_controller #(
    parameter int LEN        = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DUMP_WORDS = 4,
    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
    localparam int DW = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
    input  logic           CLK100MHZ,
    input  logic           SWITCH_RESET,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [7:0]     tx_data,
    output logic           tx_start,
    input  logic           tx_busy,
    output logic           imem_we,
    output logic [AW-1:0]  imem_addr,
    output logic [LEN-1:0] imem_wdata,
    output logic           cpu_enable,
    output logic           cpu_reset,
    input  logic           cpu_halt,
    output logic [DW-1:0]  dump_addr,
    input  logic [LEN-1:0] dump_data,
    output logic [2:0]     state_o
);

    localparam int BYTES = LEN / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WW    = $clog2(DUMP_WORDS + 1);

    localparam logic [7:0] CMD_START   = 8'h01;
    localparam logic [7:0] CMD_CONT    = 8'h02;
    localparam logic [7:0] CMD_STEPBS  = 8'h03;
    localparam logic [7:0] CMD_REPROG  = 8'h05;
    localparam logic [7:0] CMD_STEP    = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROG  = 3'd1,
        S_READY = 3'd2,
        S_CONT  = 3'd3,
        S_STEP  = 3'd4,
        S_DUMP  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        D_WAIT,
        D_LOAD,
        D_SEND,
        D_GUARD
    } dphase_t;

    state_t         state;
    state_t         post_state;
    dphase_t        dphase;
    logic [BW-1:0]  byte_idx;
    logic [LEN-1:0] asm_word;
    logic [AW-1:0]  prog_addr;
    logic [LEN-1:0] cycle_cnt;
    logic           step_active;
    logic [WW-1:0]  word_idx;
    logic [BW-1:0]  tx_idx;
    logic [LEN-1:0] tx_word;

    logic [LEN-1:0] word_next;
    logic           word_done;

    // Bytes arrive LSB first: each new byte enters at the top and the word shifts down.
    assign word_next = (asm_word >> 8) | (LEN'(rx_data) << (LEN - 8));
    assign word_done = (byte_idx == BW'(BYTES - 1));
    assign state_o   = state;

    always_ff @(posedge CLK100MHZ or negedge SWITCH_RESET) begin
        if (!SWITCH_RESET) begin
            state       <= S_IDLE;
            post_state  <= S_READY;
            dphase      <= D_WAIT;
            byte_idx    <= '0;
            asm_word    <= '0;
            prog_addr   <= '0;
            cycle_cnt   <= '0;
            step_active <= 1'b0;
            word_idx    <= '0;
            tx_idx      <= '0;
            tx_word     <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            cpu_enable  <= 1'b0;
            cpu_reset   <= 1'b1;
            dump_addr   <= '0;
        end else begin
            imem_we  <= 1'b0;
            tx_start <= 1'b0;
            if (cpu_enable) begin
                cycle_cnt <= cycle_cnt + LEN'(1);
            end

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_REPROG) begin
                            state     <= S_PROG;
                            cpu_reset <= 1'b1;
                            byte_idx  <= '0;
                            prog_addr <= '0;
                            imem_addr <= '0;
                            cycle_cnt <= '0;
                        end else if (rx_data == CMD_START) begin
                            state     <= S_READY;
                            cpu_reset <= 1'b0;
                        end
                    end
                end

                S_PROG: begin
                    if (rx_valid) begin
                        asm_word <= word_next;
                        if (word_done) begin
                            byte_idx   <= '0;
                            imem_we    <= 1'b1;
                            imem_wdata <= word_next;
                            imem_addr  <= prog_addr;
                            prog_addr  <= prog_addr + AW'(1);
                            if ((&word_next) || (prog_addr == AW'(IMEM_DEPTH - 1))) begin
                                state     <= S_READY;
                                cpu_reset <= 1'b0;
                            end
                        end else begin
                            byte_idx <= byte_idx + BW'(1);
                        end
                    end
                end

                S_READY: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_CONT) begin
                            state      <= S_CONT;
                            cpu_enable <= 1'b1;
                        end else if (rx_data == CMD_STEPBS) begin
                            state <= S_STEP;
                        end else if (rx_data == CMD_REPROG) begin
                            state     <= S_PROG;
                            cpu_reset <= 1'b1;
                            byte_idx  <= '0;
                            prog_addr <= '0;
                            imem_addr <= '0;
                            cycle_cnt <= '0;
                        end
                    end
                end

                S_CONT: begin
                    // The halt cycle itself is still enabled; gating stops on the next one.
                    if (cpu_halt) begin
                        cpu_enable <= 1'b0;
                        post_state <= S_READY;
                        state      <= S_DUMP;
                        dphase     <= D_WAIT;
                        dump_addr  <= '0;
                        word_idx   <= '0;
                        tx_idx     <= '0;
                    end
                end

                S_STEP: begin
                    if (step_active) begin
                        step_active <= 1'b0;
                        cpu_enable  <= 1'b0;
                        post_state  <= cpu_halt ? S_READY : S_STEP;
                        state       <= S_DUMP;
                        dphase      <= D_WAIT;
                        dump_addr   <= '0;
                        word_idx    <= '0;
                        tx_idx      <= '0;
                    end else if (rx_valid) begin
                        if (rx_data == CMD_STEP) begin
                            cpu_enable  <= 1'b1;
                            step_active <= 1'b1;
                        end else if (rx_data == CMD_CONT) begin
                            state      <= S_CONT;
                            cpu_enable <= 1'b1;
                        end
                    end
                end

                S_DUMP: begin
                    case (dphase)
                        D_WAIT: begin
                            dphase <= D_LOAD;
                        end
                        D_LOAD: begin
                            tx_word <= (word_idx == '0) ? cycle_cnt : dump_data;
                            dphase  <= D_SEND;
                        end
                        D_SEND: begin
                            if (!tx_busy) begin
                                tx_data  <= tx_word[7:0];
                                tx_start <= 1'b1;
                                tx_word  <= tx_word >> 8;
                                dphase   <= D_GUARD;
                            end
                        end
                        default: begin
                            // Guard cycle: the UART has not yet had a chance to raise tx_busy.
                            if (tx_idx == BW'(BYTES - 1)) begin
                                tx_idx <= '0;
                                if (word_idx == WW'(DUMP_WORDS)) begin
                                    state <= post_state;
                                end else begin
                                    dump_addr <= DW'(word_idx);
                                    word_idx  <= word_idx + WW'(1);
                                    dphase    <= D_WAIT;
                                end
                            end else begin
                                tx_idx <= tx_idx + BW'(1);
                                dphase <= D_SEND;
                            end
                        end
                    endcase
                end

                default: begin
                    state     <= S_IDLE;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_run_controller.sv
// tb/tb_debug_run_controller.sv - directed self-checking bench for debug_run_controller
module tb_debug_run_controller;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_enable;
    logic        cpu_reset;
    logic        cpu_halt;
    logic [1:0]  dump_addr;
    logic [31:0] dump_data;
    logic [2:0]  state_o;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    debug_run_controller dut (
        .CLK100MHZ    (clk),
        .SWITCH_RESET (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_enable   (cpu_enable),
        .cpu_reset    (cpu_reset),
        .cpu_halt     (cpu_halt),
        .dump_addr    (dump_addr),
        .dump_data    (dump_data),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] model_word(input logic [1:0] a);
        logic [7:0] a8;
        a8 = {6'd0, a};
        return {8'h40 + a8, 8'h30 + a8, 8'h20 + a8, 8'h10 + a8};
    endfunction

    function automatic logic [7:0] exp_dump_byte(input logic [31:0] cnt, input int i);
        int w;
        int b;
        logic [31:0] word;
        w = i / 4;
        b = i % 4;
        word = (w == 0) ? cnt : model_word(2'(w - 1));
        return word[8*b +: 8];
    endfunction

    // Core register-file stand-in: one cycle of read latency after dump_addr moves.
    always @(posedge clk) dump_data <= model_word(dump_addr);

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (tx_start) tx_q.push_back(tx_data);
        if (cpu_enable) en_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_for_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state_o !== s; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); end
        checks++; if ({tx_start, imem_we, cpu_enable} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {tx_start, imem_we, cpu_enable}); end
        checks++; if ({tx_data, imem_addr, dump_addr} !== 18'd0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {tx_data, imem_addr, dump_addr}); end
        checks++; if (imem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_program;
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h05);
        checks++; if (state_o !== 3'd1 || cpu_reset !== 1'b1) begin errors++; $display("FAIL prog_entry: got state %0d rst %b expected 1 1", state_o, cpu_reset); end
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL prog_we0: got %b expected 1", imem_we); end
        checks++; if (imem_addr !== 8'd0 || imem_wdata !== 32'h12345678) begin errors++; $display("FAIL prog_word0: got %h/%h expected 00/12345678", imem_addr, imem_wdata); end
        @(negedge clk);
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL prog_we_pulse: got %b expected 0", imem_we); end
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL prog_word1: got %b %h/%h expected 1 01/ffffffff", imem_we, imem_addr, imem_wdata); end
        repeat (2) @(negedge clk);
        checks++; if (state_o !== 3'd2 || cpu_reset !== 1'b0) begin errors++; $display("FAIL prog_exit: got state %0d rst %b expected 2 0", state_o, cpu_reset); end
        checks++; if (wr_addr_q.size() !== 2) begin errors++; $display("FAIL prog_count: got %0d writes expected 2", wr_addr_q.size()); end
    endtask

    task automatic test_continuous;
        tx_q.delete();
        en_cnt = 0;
        send_byte(8'h02);
        checks++; if (state_o !== 3'd3 || cpu_enable !== 1'b1) begin errors++; $display("FAIL cont_entry: got state %0d en %b expected 3 1", state_o, cpu_enable); end
        repeat (9) @(negedge clk);
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL cont_run: got %b expected 1", cpu_enable); end
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        checks++; if (cpu_enable !== 1'b0 || state_o !== 3'd5) begin errors++; $display("FAIL cont_halt: got en %b state %0d expected 0 5", cpu_enable, state_o); end
        wait_for_state(3'd2, 500);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL cont_ready: got %0d expected 2", state_o); end
        checks++; if (en_cnt !== 10) begin errors++; $display("FAIL cont_enabled_cycles: got %0d expected 10", en_cnt); end
        checks++; if (tx_q.size() !== 20) begin errors++; $display("FAIL cont_dump_len: got %0d expected 20", tx_q.size()); end
        for (int i = 0; i < 20 && i < tx_q.size(); i++) begin
            checks++; if (tx_q[i] !== exp_dump_byte(32'd10, i)) begin errors++; $display("FAIL cont_dump_byte%0d: got %h expected %h", i, tx_q[i], exp_dump_byte(32'd10, i)); end
        end
    endtask

    task automatic test_prog_full;
        int bad;
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h05);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = 32'(i + 1);
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
        end
        repeat (2) @(negedge clk);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL full_ready: got %0d expected 2", state_o); end
        checks++; if (wr_addr_q.size() !== 256) begin errors++; $display("FAIL full_count: got %0d expected 256", wr_addr_q.size()); end
        bad = 0;
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 32'(i + 1)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_contents: got %0d bad writes expected 0", bad); end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (2) @(negedge clk);
        checks++; if (wr_addr_q.size() !== 256 || state_o !== 3'd2) begin errors++; $display("FAIL full_no_extra: got %0d writes state %0d expected 256 2", wr_addr_q.size(), state_o); end
    endtask

    task automatic test_step;
        en_cnt = 0;
        send_byte(8'h03);
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL step_entry: got %0d expected 4", state_o); end
        for (int k = 1; k <= 3; k++) begin
            tx_q.delete();
            send_byte(8'h06);
            checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL step%0d_enable: got %b expected 1", k, cpu_enable); end
            @(negedge clk);
            checks++; if (cpu_enable !== 1'b0 || state_o !== 3'd5 || dump_addr !== 2'd0) begin errors++; $display("FAIL step%0d_dump_start: got en %b state %0d addr %0d expected 0 5 0", k, cpu_enable, state_o, dump_addr); end
            wait_for_state(3'd4, 500);
            checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL step%0d_return: got %0d expected 4", k, state_o); end
            checks++; if (tx_q.size() !== 20) begin errors++; $display("FAIL step%0d_dump_len: got %0d expected 20", k, tx_q.size()); end
            for (int i = 0; i < 20 && i < tx_q.size(); i++) begin
                checks++; if (tx_q[i] !== exp_dump_byte(32'(k), i)) begin errors++; $display("FAIL step%0d_byte%0d: got %h expected %h", k, i, tx_q[i], exp_dump_byte(32'(k), i)); end
            end
        end
        checks++; if (en_cnt !== 3) begin errors++; $display("FAIL step_enabled_cycles: got %0d expected 3", en_cnt); end
    endtask

    task automatic test_busy_hold;
        logic [7:0] held;
        int bad_start;
        int bad_data;
        tx_q.delete();
        send_byte(8'h06);
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) @(negedge clk);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL busy_first_start: got %b expected 1", tx_start); end
        tx_busy = 1'b1;
        held = tx_data;
        bad_start = 0;
        bad_data = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) bad_start++;
            if (tx_data !== held) bad_data++;
        end
        checks++; if (bad_start !== 0) begin errors++; $display("FAIL busy_no_start: got %0d pulses expected 0", bad_start); end
        checks++; if (bad_data !== 0) begin errors++; $display("FAIL busy_data_stable: got %0d changes expected 0", bad_data); end
        tx_busy = 1'b0;
        wait_for_state(3'd4, 500);
        checks++; if (tx_q.size() !== 20) begin errors++; $display("FAIL busy_dump_len: got %0d expected 20", tx_q.size()); end
        checks++; if (tx_q.size() > 0 && tx_q[0] !== 8'd4) begin errors++; $display("FAIL busy_counter: got %h expected 04", tx_q[0]); end
    endtask

    task automatic test_reset_mid_dump;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h01);
        checks++; if (state_o !== 3'd2 || cpu_reset !== 1'b0) begin errors++; $display("FAIL start_cmd: got state %0d rst %b expected 2 0", state_o, cpu_reset); end
        send_byte(8'h03);
        send_byte(8'h06);
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0 || state_o !== 3'd0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL dump_abort: got start %b state %0d rst %b expected 0 0 1", tx_start, state_o, cpu_reset); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_prog;
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (state_o !== 3'd0 || imem_we !== 1'b0) begin errors++; $display("FAIL prog_abort: got state %0d we %b expected 0 0", state_o, imem_we); end
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h05);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 32'h04030201) begin errors++; $display("FAIL reprog_word0: got %b %h/%h expected 1 00/04030201", imem_we, imem_addr, imem_wdata); end
        @(negedge clk);
        checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL reprog_count: got %0d expected 1", wr_addr_q.size()); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        cpu_halt = 1'b0;
        test_reset();
        test_program();
        test_continuous();
        test_prog_full();
        test_step();
        test_busy_hold();
        test_reset_mid_dump();
        test_reset_mid_prog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_run_controller.md
# debug_run_controller

Parametrised run-control and debug controller that sits between the UART byte interface and the pipelined MIPS core. It decodes the host command bytes (re-program, continuous, step-by-step, step) and loads the instruction memory from the byte stream. It gates the core clock-enable, then streams a configurable state dump (cycle counter plus DUMP_WORDS core words) back over UART after every step and at halt. It is the next generation of the fixed-width debug unit: LEN, memory depth and dump size are generic, and it adds a cycle counter and a stepping/continuous mode switch.

## Interface
- LEN, 32, core word width; multiple of 8
- IMEM_DEPTH, 256, instruction-memory depth in words (power of 2)
- DUMP_WORDS, 4, core words sent per dump (≥1)
- CLK100MHZ  in  1  system clock, all logic rising-edge
- SWITCH_RESET  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle pulse, rx_data valid
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART transmitter busy
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  clog2(IMEM_DEPTH)  write address
- imem_wdata  out  LEN  write data
- cpu_enable  out  1  core clock-enable
- cpu_reset  out  1  active-high core reset
- cpu_halt  in  1  HALT reached write-back
- dump_addr  out  clog2(DUMP_WORDS)  dump word select
- dump_data  in  LEN  selected word; valid one cycle after dump_addr changes
- state_o  out  3  FSM state code, for LEDs

## Operation
- Commands: 0x01 Start, 0x02 Continuous, 0x03 StepByStep, 0x05 ReProgram, 0x06 Step. Any other byte is ignored. A byte that is not legal in the current state is ignored.
- States and codes:
  - IDLE=0: wait for ReProgram or Start. Start goes to READY with the existing memory contents.
  - PROG=1: assemble LEN/8 bytes LSB-first into a word, write it, then increment the address. Exit to READY after writing the all-ones word (HALT encoding) or after writing address IMEM_DEPTH-1.
  - READY=2: Continuous goes to CONT. StepByStep goes to STEP. ReProgram goes to PROG.
  - CONT=3: cpu_enable=1 until cpu_halt, then DUMP, then READY.
  - STEP=4: Step gives one enabled cycle, then DUMP, then back to STEP. Continuous goes to CONT. If cpu_halt was high on the enabled cycle, the post-dump state is READY.
  - DUMP=5: send the cycle counter, then dump words 0..DUMP_WORDS-1. Each word is sent as LEN/8 bytes, LSB first.
- cpu_reset=1 in IDLE and PROG.
- Entering PROG clears the byte index, imem_addr and the cycle counter.
- Cycle counter: LEN bits, +1 each cycle cpu_enable=1, wraps to 0.
- rx_valid is ignored in CONT and DUMP.
- Reset values: cpu_reset=1, state=IDLE, all other outputs 0, counters 0.

## Timing
- rx_valid at cycle t changes state at t+1.
- Step at t: cpu_enable=1 in cycle t+1 only; dump_addr is set at t+2.
- Continuous at t: cpu_enable=1 from t+1.
- cpu_halt sampled high at h: the halt cycle itself is enabled; cpu_enable=0 from h+1.
- PROG: the last byte of a word at t gives imem_we=1 for exactly cycle t+1, with imem_addr/imem_wdata valid in that cycle.
- TX handshake:
  - tx_start pulses only when tx_busy=0; tx_data is held until tx_busy rises.
  - After each pulse, wait one guard cycle before re-sampling tx_busy.
  - tx_busy stuck low means one byte per 2 cycles.
- DUMP: dump_data is sampled one cycle after each dump_addr update. Total bytes sent = (DUMP_WORDS+1)·LEN/8.
- Reset asserted mid-operation: immediate return to reset values.
  - A partial program word is discarded.
  - A dump in progress is abandoned and tx_start drops.

## Test plan
- Reset, then 0x05 and bytes 78 56 34 12 FF FF FF FF:
  - imem_we at addr 0 with 0x12345678;
  - imem_we at addr 1 with 0xFFFFFFFF;
  - then state_o=2 and cpu_reset=0.
- Program IMEM_DEPTH non-halt words: the last write is to addr IMEM_DEPTH-1 and the FSM enters READY. No further writes occur.
- 0x03 then three 0x06 (tx_busy tied low):
  - exactly 3 single enable cycles;
  - 3 dumps of 20 bytes each (LEN=32, DUMP_WORDS=4);
  - counter words are 1, 2, 3.
- 0x02 with cpu_halt raised on the 10th enabled cycle: cpu_enable falls the next cycle, the dump counter word is 10, and the FSM ends in READY.
- During a dump, hold tx_busy high for 50 cycles: no tx_start is issued and tx_data stays stable.
- Assert SWITCH_RESET low mid-PROG after 2 bytes, then reprogram: the first write is to addr 0 with only the new bytes.
